// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the fetch sequencer
package fetch_pkg;
  localparam int ADDR_W_DEF = 11;
  localparam int RESET_VEC_DEF = 'h000;
  localparam int IRQ_VEC_DEF = 'h7F0;
  typedef enum logic [1:0] {BOOT, RUN, ISR} state_t;
  typedef enum logic [2:0] {NONE, EX, IRQ, IRET, ID, HOLD, INC} src_t;
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: pipeline-side redirect requests and fetch outputs of the sequencer
interface fetch_sequencer_if #(parameter int ADDR_W = fetch_pkg::ADDR_W_DEF);
  logic stall;
  logic ex_branch_valid;
  logic [ADDR_W-1:0] ex_branch_addr;
  logic id_jump_valid;
  logic [ADDR_W-1:0] id_jump_addr;
  logic irq_req;
  logic iret;
  logic [ADDR_W-1:0] pc;
  logic pc_valid;
  logic flush_id;
  logic flush_ex;
  logic irq_ack;
  modport master(
    input stall, ex_branch_valid, ex_branch_addr, id_jump_valid, id_jump_addr, irq_req, iret,
    output pc, pc_valid, flush_id, flush_ex, irq_ack
  );
  modport slave(
    output stall, ex_branch_valid, ex_branch_addr, id_jump_valid, id_jump_addr, irq_req, iret,
    input pc, pc_valid, flush_id, flush_ex, irq_ack
  );
endinterface

// File: rtl/fetch_sequencer_redirect_arbiter.sv
// redirect_arbiter: combinational priority select of the next fetch address and its source
module redirect_arbiter
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] IRQ_VEC = ADDR_W'(IRQ_VEC_DEF)
) (
  input  state_t            state,
  input  logic              stall,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_addr,
  input  logic              irq_req,
  input  logic              iret,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] epc,
  output src_t              src,
  output logic [ADDR_W-1:0] next_pc
);
  // execute branches win even over stall; everything else waits for stall to drop
  always_comb begin
    src = state == BOOT ? NONE
        : ex_valid ? EX
        : (state == RUN && irq_req && !stall) ? IRQ
        : (state == ISR && iret && !stall) ? IRET
        : (id_valid && !stall) ? ID
        : stall ? HOLD : INC;
    next_pc = src == EX ? ex_addr
            : src == IRQ ? IRQ_VEC
            : src == IRET ? epc
            : src == ID ? id_addr
            : src == INC ? pc + 1'b1 : pc;
  end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program counter and issues flush pulses on redirects
// Interrupt entry/return (ISR state, epc, irq_ack) is built only when FETCH_IRQ_EN is defined.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF),
  parameter logic [ADDR_W-1:0] IRQ_VEC = ADDR_W'(IRQ_VEC_DEF)
) (
  input logic clk,
  input logic resetn,
  fetch_sequencer_if.master bus
);
  state_t state_q, state_d;
  src_t src;
  logic [ADDR_W-1:0] pc_q, next_pc, epc;
  logic pc_valid_q, flush_id_q, flush_ex_q, flush_id_d, flush_ex_d;
  logic irq_req, iret;
  redirect_arbiter #(.ADDR_W(ADDR_W), .IRQ_VEC(IRQ_VEC)) u_arb (
    .state(state_q), .stall(bus.stall),
    .ex_valid(bus.ex_branch_valid), .ex_addr(bus.ex_branch_addr),
    .id_valid(bus.id_jump_valid), .id_addr(bus.id_jump_addr),
    .irq_req(irq_req), .iret(iret), .pc(pc_q), .epc(epc),
    .src(src), .next_pc(next_pc)
  );
  always_comb begin
    state_d = state_q;
    state_d = (state_q == BOOT || src == IRET) ? RUN : src == IRQ ? ISR : state_q;
    flush_id_d = src inside {EX, IRQ, IRET, ID};
    flush_ex_d = src == EX;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= BOOT;
      pc_q <= RESET_VEC;
      pc_valid_q <= 1'b0;
      flush_id_q <= 1'b0;
      flush_ex_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= next_pc;
      pc_valid_q <= 1'b1;
      flush_id_q <= flush_id_d;
      flush_ex_q <= flush_ex_d;
    end
  end
`ifdef FETCH_IRQ_EN
  logic [ADDR_W-1:0] epc_q;
  logic irq_ack_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      epc_q <= '0;
      irq_ack_q <= 1'b0;
    end else begin
      epc_q <= src == IRQ ? pc_q : epc_q;
      irq_ack_q <= src == IRQ;
    end
  end
  assign irq_req = bus.irq_req;
  assign iret = bus.iret;
  assign epc = epc_q;
  assign bus.irq_ack = irq_ack_q;
`else
  logic unused_irq;
  assign unused_irq = bus.irq_req ^ bus.iret;
  assign irq_req = 1'b0;
  assign iret = 1'b0;
  assign epc = '0;
  assign bus.irq_ack = 1'b0;
`endif
  assign bus.pc = pc_q;
  assign bus.pc_valid = pc_valid_q;
  assign bus.flush_id = flush_id_q;
  assign bus.flush_ex = flush_ex_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench with a behavioural PC model and randomized redirects
module tb_fetch_sequencer;
  import fetch_pkg::*;
  localparam int AW = 11;
  localparam int RV = 'h000;
  localparam int IV = 'h7F0;
`ifdef FETCH_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  typedef struct {
    int pc;
    bit v, fid, fex, ack;
  } exp_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  bit booted, in_isr;
  int m_pc, m_epc;
  always #5 clk = ~clk;
  fetch_sequencer_if #(.ADDR_W(AW)) bus();
  fetch_sequencer #(.ADDR_W(AW), .RESET_VEC(AW'(RV)), .IRQ_VEC(AW'(IV))) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", n, got, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc", bus.pc, e.pc);
      chk("pc_valid", bus.pc_valid, e.v);
      chk("flush_id", bus.flush_id, e.fid);
      chk("flush_ex", bus.flush_ex, e.fex);
      chk("irq_ack", bus.irq_ack, e.ack);
    end
  end
  task automatic step(input bit st, input bit ex, input int exa, input bit id, input int ida,
                      input bit irq, input bit ir);
    exp_t e;
    bus.stall = st;
    bus.ex_branch_valid = ex;
    bus.ex_branch_addr = exa[AW-1:0];
    bus.id_jump_valid = id;
    bus.id_jump_addr = ida[AW-1:0];
    bus.irq_req = irq;
    bus.iret = ir;
    e.fid = 0; e.fex = 0; e.ack = 0; e.v = 1;
    if (!booted) booted = 1;
    else if (ex) begin m_pc = exa; e.fid = 1; e.fex = 1; end
    else if (IRQ_EN && !in_isr && irq && !st) begin
      m_epc = m_pc; m_pc = IV; in_isr = 1; e.fid = 1; e.ack = 1;
    end else if (IRQ_EN && in_isr && ir && !st) begin
      m_pc = m_epc; in_isr = 0; e.fid = 1;
    end else if (id && !st) begin m_pc = ida; e.fid = 1; end
    else if (!st) m_pc = (m_pc + 1) % 2048;
    e.pc = m_pc;
    q.push_back(e);
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic reset_check(input string n);
    resetn = 1'b0;
    #1;
    chk({n, "_pc"}, bus.pc, RV);
    chk({n, "_valid"}, bus.pc_valid, 0);
    chk({n, "_fid"}, bus.flush_id, 0);
    chk({n, "_fex"}, bus.flush_ex, 0);
    chk({n, "_ack"}, bus.irq_ack, 0);
    booted = 0; in_isr = 0; m_pc = RV; m_epc = 0;
  endtask
  initial begin
    bus.stall = 0; bus.ex_branch_valid = 0; bus.ex_branch_addr = '0;
    bus.id_jump_valid = 0; bus.id_jump_addr = '0; bus.irq_req = 0; bus.iret = 0;
    repeat (2) @(negedge clk);
    reset_check("por");
    @(negedge clk);
    resetn = 1'b1;
    idle(4);
    step(0, 0, 0, 1, 2047, 0, 0);
    idle(2);
    step(1, 1, 'h100, 1, 'h200, 0, 0);
    idle(1);
    step(0, 0, 0, 1, 'h010, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 'h300, 0, 0);
    idle(1);
    step(0, 0, 0, 1, 'h020, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 'h055, 0, 0, 0, 1);
    step(0, 0, 0, 1, 'h3AA, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 0);
    #2;
    reset_check("mid_isr");
    @(negedge clk);
    resetn = 1'b1;
    idle(3);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 2047),
           $urandom_range(0, 5) == 0, $urandom_range(0, 2047),
           $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0);
    idle(2);
    @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
